// File: rtl/pe_port_master_pkg.sv
// -----------------------------------------------------------------------------
// pe_port_master_pkg
//
// Shared definitions for the PE-port Avalon-MM master and its buffer FIFO:
//   - rd_state_t : read FSM state encoding (IDLE=0, RD=1, CAP=2)
//   - DEF_*      : default width/depth constants used as parameter defaults
// -----------------------------------------------------------------------------
package pe_port_master_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        CAP  = 2'd2
    } rd_state_t;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_TX_DEPTH   = 4;
    localparam int DEF_RX_DEPTH   = 4;
    localparam int DEF_CNT_WIDTH  = 4;

endpackage

// File: rtl/pe_buf_fifo.sv
// -----------------------------------------------------------------------------
// pe_buf_fifo
//
// Small synchronous FIFO used for both the transmit and receive buffers of
// pe_port_master. Depth must be a power of two (>= 2) so the pointers wrap
// naturally.
//
// Ports:
//   clock      : clock
//   reset      : synchronous, active-low reset (empties the FIFO)
//   push       : write push_data (ignored while full)
//   push_data  : word to write
//   pop        : drop the head word (ignored while empty)
//   pop_data   : head word (valid while !empty)
//   full/empty : occupancy flags
//   count      : number of stored words
// -----------------------------------------------------------------------------
module pe_buf_fifo
    import pe_port_master_pkg::*;
#(
    parameter int DataWidth = DEF_DATA_WIDTH,
    parameter int Depth     = DEF_TX_DEPTH
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   push,
    input  logic [DataWidth-1:0]   push_data,
    input  logic                   pop,
    output logic [DataWidth-1:0]   pop_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(Depth):0] count
);

    localparam int PtrWidth = $clog2(Depth);
    localparam logic [PtrWidth:0] FullCount = (PtrWidth + 1)'(Depth);

    logic [DataWidth-1:0] mem [Depth];
    logic [PtrWidth-1:0]  wr_ptr;
    logic [PtrWidth-1:0]  rd_ptr;
    logic                 do_push;
    logic                 do_pop;

    assign full     = (count == FullCount);
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // Storage array; needs no reset because the pointers define what is valid.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers and occupancy; a simultaneous push and pop leaves count unchanged.
    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/pe_port_master.sv
// -----------------------------------------------------------------------------
// pe_port_master
//
// Avalon-MM-style master for one PE port of the 2x2 NoC adaptor. Words from
// the local source are buffered and written to the adaptor; adaptor irq
// pulses are counted and serviced by reads whose data is buffered for the
// local sink.
//
// Ports:
//   clock, reset              : clock, synchronous active-low reset
//   tx_data/tx_valid/tx_ready : local source handshake into the TX buffer
//   rx_data/rx_valid/rx_ready : local sink handshake out of the RX buffer
//   av_writeData/av_write     : adaptor write path, TX head presented
//   av_waiteRequest           : high = adaptor accepts the write this cycle
//   av_read                   : adaptor FIFO pop, one-cycle pulse
//   av_reaData                : adaptor read data, valid the cycle after av_read
//   av_irq                    : one pulse per word pushed into the adaptor FIFO
//   pending_count             : words signalled but not yet read
//   overflow                  : sticky pending-counter saturation flag
// -----------------------------------------------------------------------------
module pe_port_master
    import pe_port_master_pkg::*;
#(
    parameter int DataWidth = DEF_DATA_WIDTH,
    parameter int TxDepth   = DEF_TX_DEPTH,
    parameter int RxDepth   = DEF_RX_DEPTH,
    parameter int CntWidth  = DEF_CNT_WIDTH
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [DataWidth-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic [DataWidth-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic [DataWidth-1:0] av_writeData,
    output logic                 av_write,
    input  logic                 av_waiteRequest,
    output logic                 av_read,
    input  logic [DataWidth-1:0] av_reaData,
    input  logic                 av_irq,
    output logic [CntWidth-1:0]  pending_count,
    output logic                 overflow
);

    localparam int TxCntWidth = $clog2(TxDepth) + 1;
    localparam int RxCntWidth = $clog2(RxDepth) + 1;
    localparam logic [RxCntWidth-1:0] RxDepthCnt = RxCntWidth'(RxDepth);
    localparam logic [RxCntWidth-1:0] TwoSlots   = RxCntWidth'(2);
    localparam logic [CntWidth-1:0]   CntMax     = '1;

    rd_state_t               state;
    rd_state_t               state_next;
    logic                    out_enable;
    logic                    tx_push;
    logic                    tx_pop;
    logic                    tx_full;
    logic                    tx_empty;
    logic [TxCntWidth-1:0]   tx_count;
    logic                    rx_push;
    logic                    rx_pop;
    logic                    rx_full;
    logic                    rx_empty;
    logic [RxCntWidth-1:0]   rx_count;
    logic [RxCntWidth-1:0]   rx_free;
    logic                    unused_tx_count;

    // Holds tx_ready low during reset and for the reset-release edge itself,
    // so the source only sees ready from the first cycle after release.
    always_ff @(posedge clock) begin
        if (!reset) begin
            out_enable <= 1'b0;
        end else begin
            out_enable <= 1'b1;
        end
    end

    assign tx_ready     = out_enable && !tx_full;
    assign tx_push      = tx_valid && tx_ready;
    assign av_write     = !tx_empty;
    assign tx_pop       = av_write && av_waiteRequest;

    pe_buf_fifo #(
        .DataWidth (DataWidth),
        .Depth     (TxDepth)
    ) u_tx_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (tx_push),
        .push_data (tx_data),
        .pop       (tx_pop),
        .pop_data  (av_writeData),
        .full      (tx_full),
        .empty     (tx_empty),
        .count     (tx_count)
    );

    // TX occupancy is not needed beyond the full/empty flags.
    assign unused_tx_count = ^tx_count;

    assign rx_valid = !rx_empty;
    assign rx_pop   = rx_valid && rx_ready;
    assign rx_free  = RxDepthCnt - rx_count;

    pe_buf_fifo #(
        .DataWidth (DataWidth),
        .Depth     (RxDepth)
    ) u_rx_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (rx_push),
        .push_data (av_reaData),
        .pop       (rx_pop),
        .pop_data  (rx_data),
        .full      (rx_full),
        .empty     (rx_empty),
        .count     (rx_count)
    );

    // Pending counter: irq adds, a read issue subtracts, both together cancel.
    // At the maximum an unmatched irq is dropped and flagged until reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            pending_count <= '0;
            overflow      <= 1'b0;
        end else begin
            case ({av_irq, av_read})
                2'b10: begin
                    if (pending_count == CntMax) begin
                        overflow <= 1'b1;
                    end else begin
                        pending_count <= pending_count + 1'b1;
                    end
                end
                2'b01:   pending_count <= pending_count - 1'b1;
                default: pending_count <= pending_count;
            endcase
        end
    end

    // Read FSM state register.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Read FSM next state and outputs. An RX slot is reserved when RD is
    // entered; in CAP the word being captured is not yet in rx_count, so two
    // free slots are needed to launch the next read back to back.
    always_comb begin
        state_next = state;
        av_read    = 1'b0;
        rx_push    = 1'b0;
        case (state)
            IDLE: begin
                if ((pending_count != '0) && !rx_full) begin
                    state_next = RD;
                end
            end
            RD: begin
                av_read    = 1'b1;
                state_next = CAP;
            end
            CAP: begin
                rx_push = 1'b1;
                if ((pending_count != '0) && (rx_free >= TwoSlots)) begin
                    state_next = RD;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_pe_port_master.sv
// -----------------------------------------------------------------------------
// tb_pe_port_master
//
// Directed testbench for pe_port_master. Inputs change 1 time unit after the
// rising edge, outputs are checked on the falling edge. The adaptor's FIFO is
// modelled as a queue: words are queued with each irq pulse and returned on
// av_reaData the cycle after av_read.
// -----------------------------------------------------------------------------
module tb_pe_port_master;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic [7:0] av_writeData;
    logic       av_write;
    logic       av_waiteRequest;
    logic       av_read;
    logic [7:0] av_reaData;
    logic       av_irq;
    logic [3:0] pending_count;
    logic       overflow;

    int         total_checks = 0;
    int         bad_checks   = 0;
    logic [7:0] adaptor_q[$];
    logic [7:0] got_q[$];
    int         read_count;

    always #5 clock = ~clock;

    pe_port_master #(
        .DataWidth (8),
        .TxDepth   (4),
        .RxDepth   (4),
        .CntWidth  (4)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .tx_data         (tx_data),
        .tx_valid        (tx_valid),
        .tx_ready        (tx_ready),
        .rx_data         (rx_data),
        .rx_valid        (rx_valid),
        .rx_ready        (rx_ready),
        .av_writeData    (av_writeData),
        .av_write        (av_write),
        .av_waiteRequest (av_waiteRequest),
        .av_read         (av_read),
        .av_reaData      (av_reaData),
        .av_irq          (av_irq),
        .pending_count   (pending_count),
        .overflow        (overflow)
    );

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total_checks++;
        if (observed !== expected) begin
            bad_checks++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Drives one cycle's worth of inputs; an irq also queues its word in the
    // adaptor model.
    task automatic applyStimulus(input logic tv, input logic [7:0] td,
                                 input logic wreq, input logic irq,
                                 input logic [7:0] idata, input logic rrdy);
        tx_valid        = tv;
        tx_data         = td;
        av_waiteRequest = wreq;
        av_irq          = irq;
        rx_ready        = rrdy;
        if (irq) begin
            adaptor_q.push_back(idata);
        end
    endtask

    // Advances one clock; returns adaptor data after a cycle with av_read.
    task automatic stepClock();
        logic rd;
        rd = av_read;
        @(posedge clock);
        #1;
        if (rd) begin
            if (adaptor_q.size() > 0) begin
                av_reaData = adaptor_q.pop_front();
            end else begin
                av_reaData = 8'hEE;
            end
        end
    endtask

    // Idle cycles with the given rx_ready, recording sink pops and reads.
    task automatic idleCycles(input int n, input logic rrdy);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, rrdy);
            @(negedge clock);
            if (av_read) read_count++;
            if (rx_valid && rx_ready) got_q.push_back(rx_data);
            stepClock();
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] t1_in [5];
        logic       t1_wr [5];
        logic [7:0] t1_wd [5];
        logic       t2_tv [17];
        logic [7:0] t2_td [17];
        logic       t2_wq [17];
        logic       t2_wr [17];
        logic [7:0] t2_wd [17];
        logic       t2_rdy[17];
        logic       t3_rd [10];
        logic [3:0] t3_pc [10];

        reset           = 1'b0;
        tx_valid        = 1'b0;
        tx_data         = 8'h00;
        av_waiteRequest = 1'b0;
        av_irq          = 1'b0;
        av_reaData      = 8'h00;
        rx_ready        = 1'b0;

        // ---------------- reset state ----------------
        stepClock();
        stepClock();
        @(negedge clock);
        checkOutput("rst_tx_ready", tx_ready, 0);
        checkOutput("rst_av_write", av_write, 0);
        checkOutput("rst_av_read", av_read, 0);
        checkOutput("rst_rx_valid", rx_valid, 0);
        checkOutput("rst_pending", pending_count, 0);
        checkOutput("rst_overflow", overflow, 0);
        reset = 1'b1;
        stepClock();
        @(negedge clock);
        checkOutput("rel_tx_ready", tx_ready, 1);
        checkOutput("rel_av_write", av_write, 0);
        stepClock();

        // ---------------- test 1: back-to-back writes ----------------
        t1_in = '{8'h11, 8'h22, 8'h33, 8'h00, 8'h00};
        t1_wr = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        t1_wd = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h00};
        for (int i = 0; i < 5; i++) begin
            applyStimulus(i < 3, t1_in[i], 1'b1, 1'b0, 8'h00, 1'b0);
            @(negedge clock);
            checkOutput($sformatf("t1_write_c%0d", i), av_write, t1_wr[i]);
            if (t1_wr[i]) checkOutput($sformatf("t1_wdata_c%0d", i), av_writeData, t1_wd[i]);
            stepClock();
        end

        // ---------------- test 2: stall, hold, fill ----------------
        t2_tv  = '{1,0,0,0,0,0,0,0,1,1,1,1,0,0,0,0,0};
        t2_td  = '{8'hA5,0,0,0,0,0,0,0,8'hB0,8'hB1,8'hB2,8'hB3,0,0,0,0,0};
        t2_wq  = '{0,0,0,0,0,0,1,0,0,0,0,0,1,1,1,1,1};
        t2_wr  = '{0,1,1,1,1,1,1,0,0,1,1,1,1,1,1,1,0};
        t2_wd  = '{0,8'hA5,8'hA5,8'hA5,8'hA5,8'hA5,8'hA5,0,0,
                   8'hB0,8'hB0,8'hB0,8'hB0,8'hB1,8'hB2,8'hB3,0};
        t2_rdy = '{1,1,1,1,1,1,1,1,1,1,1,1,0,1,1,1,1};
        for (int i = 0; i < 17; i++) begin
            applyStimulus(t2_tv[i], t2_td[i], t2_wq[i], 1'b0, 8'h00, 1'b0);
            @(negedge clock);
            checkOutput($sformatf("t2_write_c%0d", i), av_write, t2_wr[i]);
            checkOutput($sformatf("t2_txrdy_c%0d", i), tx_ready, t2_rdy[i]);
            if (t2_wr[i]) checkOutput($sformatf("t2_wdata_c%0d", i), av_writeData, t2_wd[i]);
            stepClock();
        end

        // ---------------- test 3: three irqs, sink always ready ----------------
        t3_rd = '{0,0,1,0,1,0,1,0,0,0};
        t3_pc = '{0,1,2,2,2,1,1,0,0,0};
        got_q.delete();
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 8'h00, 1'b0, i < 3, 8'(i + 1), 1'b1);
            @(negedge clock);
            checkOutput($sformatf("t3_read_c%0d", i), av_read, t3_rd[i]);
            checkOutput($sformatf("t3_pend_c%0d", i), pending_count, t3_pc[i]);
            if (rx_valid && rx_ready) got_q.push_back(rx_data);
            stepClock();
        end
        checkOutput("t3_rx_words", got_q.size(), 3);
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("t3_rx_data%0d", i),
                        (i < got_q.size()) ? 32'(got_q[i]) : 32'hDEAD, 32'(i + 1));
        end

        // ---------------- test 4: six irqs, sink stalled ----------------
        got_q.delete();
        read_count = 0;
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b0, 8'h00, 1'b0, i < 6, 8'(8'h41 + i), 1'b0);
            @(negedge clock);
            if (av_read) read_count++;
            stepClock();
        end
        @(negedge clock);
        checkOutput("t4_reads_stalled", read_count, 4);
        checkOutput("t4_pending_stalled", pending_count, 2);
        checkOutput("t4_rx_head", rx_data, 8'h41);
        stepClock();
        read_count = 0;
        idleCycles(24, 1'b1);
        @(negedge clock);
        checkOutput("t4_reads_drain", read_count, 2);
        checkOutput("t4_pending_drain", pending_count, 0);
        checkOutput("t4_rx_words", got_q.size(), 6);
        for (int i = 0; i < 6; i++) begin
            checkOutput($sformatf("t4_rx_data%0d", i),
                        (i < got_q.size()) ? 32'(got_q[i]) : 32'hDEAD, 32'(8'h41 + i));
        end
        stepClock();

        // ---------------- test 5: counter saturation ----------------
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 8'(8'h51 + i), 1'b0);
            stepClock();
        end
        idleCycles(12, 1'b0);
        @(negedge clock);
        checkOutput("t5_prefill_pending", pending_count, 0);
        checkOutput("t5_prefill_rxvalid", rx_valid, 1);
        stepClock();
        for (int i = 0; i < 15; i++) begin
            applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 8'(8'h60 + i), 1'b0);
            stepClock();
        end
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
        @(negedge clock);
        checkOutput("t5_pending_15", pending_count, 15);
        checkOutput("t5_overflow_pre", overflow, 0);
        stepClock();
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 8'h6F, 1'b0);
        stepClock();
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
        @(negedge clock);
        checkOutput("t5_pending_sat", pending_count, 15);
        checkOutput("t5_overflow_set", overflow, 1);
        stepClock();
        idleCycles(10, 1'b1);
        @(negedge clock);
        checkOutput("t5_overflow_sticky", overflow, 1);
        checkOutput("t5_pending_dropped", pending_count < 4'd15, 1);
        reset = 1'b0;
        stepClock();
        adaptor_q.delete();
        @(negedge clock);
        checkOutput("t5_rst_overflow", overflow, 0);
        checkOutput("t5_rst_pending", pending_count, 0);
        reset = 1'b1;
        stepClock();

        // ---------------- test 6: reset mid-stall ----------------
        applyStimulus(1'b1, 8'hC1, 1'b0, 1'b0, 8'h00, 1'b0);
        stepClock();
        applyStimulus(1'b1, 8'hC2, 1'b0, 1'b0, 8'h00, 1'b0);
        stepClock();
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 8'h77, 1'b0);
        stepClock();
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
        reset = 1'b0;
        @(negedge clock);
        checkOutput("t6_pre_write", av_write, 1);
        checkOutput("t6_pre_wdata", av_writeData, 8'hC1);
        checkOutput("t6_pre_pending", pending_count, 1);
        stepClock();
        adaptor_q.delete();
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0);
        reset = 1'b1;
        @(negedge clock);
        checkOutput("t6_rst_tx_ready", tx_ready, 0);
        checkOutput("t6_rst_av_write", av_write, 0);
        checkOutput("t6_rst_av_read", av_read, 0);
        checkOutput("t6_rst_rx_valid", rx_valid, 0);
        checkOutput("t6_rst_pending", pending_count, 0);
        checkOutput("t6_rst_overflow", overflow, 0);
        stepClock();
        @(negedge clock);
        checkOutput("t6_rel_tx_ready", tx_ready, 1);
        checkOutput("t6_rel_av_write", av_write, 0);
        checkOutput("t6_rel_pending", pending_count, 0);
        checkOutput("t6_rel_av_read", av_read, 0);

        $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
        $finish;
    end

endmodule
